// File: rtl/fifo_stream_reader.sv
// Read-side drain stage: issues FIFO reads, realigns returned words after READ_LATENCY and
// presents them on a valid/ready stream through a skid buffer sized so no word is ever lost.
module fifo_stream_reader #(
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 1,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  fifo_empty,
    output logic                  fifo_read,
    input  logic [DATA_WIDTH-1:0] fifo_read_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [2:0]            inflight,
    output logic [2:0]            buf_count,
    output logic [CNT_WIDTH-1:0]  word_count
);

    localparam int BUF_DEPTH = READ_LATENCY + 2;
    localparam int PTR_W     = $clog2(BUF_DEPTH);

    logic [READ_LATENCY-1:0] ret_vld;
    logic [DATA_WIDTH-1:0]   mem [BUF_DEPTH];
    logic [PTR_W-1:0]        head;
    logic [PTR_W-1:0]        tail;
    logic [3:0]              occupancy;
    logic                    push;
    logic                    pop;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++)
            inflight = inflight + {2'b00, ret_vld[i]};
    end

    // Counting in-flight reads against free space is what makes overflow impossible;
    // the issue decision depends only on registered state, never on m_ready.
    assign occupancy = {1'b0, buf_count} + {1'b0, inflight};
    assign fifo_read = reset_n && !fifo_empty && (occupancy < 4'(BUF_DEPTH));
    assign push      = ret_vld[READ_LATENCY-1];
    assign m_valid   = (buf_count != 3'd0);
    assign pop       = m_valid && m_ready;
    assign m_data    = mem[head];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ret_vld    <= '0;
            head       <= '0;
            tail       <= '0;
            buf_count  <= '0;
            word_count <= '0;
            for (int i = 0; i < BUF_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            ret_vld[0] <= fifo_read;
            for (int i = 1; i < READ_LATENCY; i++)
                ret_vld[i] <= ret_vld[i-1];
            if (push) begin
                mem[tail] <= fifo_read_data;
                tail      <= wrap_inc(tail);
            end
            if (pop) begin
                head       <= wrap_inc(head);
                word_count <= word_count + 1'b1;
            end
            if (push && !pop)
                buf_count <= buf_count + 3'd1;
            else if (pop && !push)
                buf_count <= buf_count - 3'd1;
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench: two instances (READ_LATENCY=1 with a 4-bit counter, READ_LATENCY=3) fed by FIFO models.
module tb_fifo_stream_reader;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       a_empty, a_rd, a_valid, a_ready;
    logic [7:0] a_rdata, a_mdata;
    logic [2:0] a_infl, a_buf;
    logic [3:0] a_wc;

    logic        b_empty, b_rd, b_valid, b_ready;
    logic [7:0]  b_rdata, b_mdata;
    logic [2:0]  b_infl, b_buf;
    logic [15:0] b_wc;
    logic [7:0]  b_stg [3];

    logic [7:0] a_pend[$], a_fifo[$], a_exp[$];
    logic [7:0] b_pend[$], b_fifo[$], b_exp[$];

    int checks = 0, passed = 0;
    int a_got = 0, b_got = 0;
    logic       a_hold = 1'b0, b_hold = 1'b0;
    logic [7:0] a_hold_dat, b_hold_dat;

    fifo_stream_reader #(.DATA_WIDTH(8), .READ_LATENCY(1), .CNT_WIDTH(4)) dut_a (
        .clk(clk), .reset_n(rst_n), .fifo_empty(a_empty), .fifo_read(a_rd),
        .fifo_read_data(a_rdata), .m_valid(a_valid), .m_ready(a_ready), .m_data(a_mdata),
        .inflight(a_infl), .buf_count(a_buf), .word_count(a_wc));

    fifo_stream_reader #(.DATA_WIDTH(8), .READ_LATENCY(3), .CNT_WIDTH(16)) dut_b (
        .clk(clk), .reset_n(rst_n), .fifo_empty(b_empty), .fifo_read(b_rd),
        .fifo_read_data(b_rdata), .m_valid(b_valid), .m_ready(b_ready), .m_data(b_mdata),
        .inflight(b_infl), .buf_count(b_buf), .word_count(b_wc));

    assign b_rdata = b_stg[2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // FIFO models: read latency 1 for A, 3 for B; every issued word is queued as expected output.
    always @(posedge clk or negedge rst_n) begin : model_a
        logic [7:0] w;
        if (!rst_n) begin
            a_pend.delete(); a_fifo.delete(); a_exp.delete();
            a_empty <= 1'b1;
            a_rdata <= '0;
        end else begin
            if (a_rd && a_fifo.size() > 0) begin
                w = a_fifo.pop_front();
                a_rdata <= w;
                a_exp.push_back(w);
            end
            while (a_pend.size() > 0) a_fifo.push_back(a_pend.pop_front());
            a_empty <= (a_fifo.size() == 0);
        end
    end

    always @(posedge clk or negedge rst_n) begin : model_b
        logic [7:0] w;
        if (!rst_n) begin
            b_pend.delete(); b_fifo.delete(); b_exp.delete();
            b_empty <= 1'b1;
            for (int i = 0; i < 3; i++) b_stg[i] <= '0;
        end else begin
            w = '0;
            if (b_rd && b_fifo.size() > 0) begin
                w = b_fifo.pop_front();
                b_exp.push_back(w);
            end
            b_stg[0] <= w;
            b_stg[1] <= b_stg[0];
            b_stg[2] <= b_stg[1];
            while (b_pend.size() > 0) b_fifo.push_back(b_pend.pop_front());
            b_empty <= (b_fifo.size() == 0);
        end
    end

    // Scoreboards and invariants, sampled mid-cycle.
    always @(negedge clk) begin : monitor
        logic [7:0] e;
        if (!rst_n) begin
            a_hold = 1'b0;
            b_hold = 1'b0;
        end else begin
            chk("a_rd_while_empty", a_rd && a_empty, 0);
            chk("b_rd_while_empty", b_rd && b_empty, 0);
            chk("a_occupancy", 32'(a_buf) + 32'(a_infl) <= 32'd3, 1);
            chk("b_occupancy", 32'(b_buf) + 32'(b_infl) <= 32'd5, 1);
            assert (32'(a_buf) + 32'(a_infl) <= 32'd3 && 32'(b_buf) + 32'(b_infl) <= 32'd5)
                else $error("FAIL buffer_overflow a=%0d+%0d b=%0d+%0d", a_buf, a_infl, b_buf, b_infl);
            if (a_hold) begin
                chk("a_hold_vld", a_valid, 1);
                chk("a_hold_dat", a_mdata, a_hold_dat);
            end
            a_hold     = a_valid && !a_ready;
            a_hold_dat = a_mdata;
            if (b_hold) begin
                chk("b_hold_vld", b_valid, 1);
                chk("b_hold_dat", b_mdata, b_hold_dat);
            end
            b_hold     = b_valid && !b_ready;
            b_hold_dat = b_mdata;
            if (a_valid && a_ready) begin
                chk("a_unexpected_word", a_exp.size() != 0, 1);
                if (a_exp.size() != 0) begin
                    e = a_exp.pop_front();
                    chk("a_data_order", a_mdata, e);
                end
                a_got++;
            end
            if (b_valid && b_ready) begin
                chk("b_unexpected_word", b_exp.size() != 0, 1);
                if (b_exp.size() != 0) begin
                    e = b_exp.pop_front();
                    chk("b_data_order", b_mdata, e);
                end
                b_got++;
            end
        end
    end

    task automatic wait_a_drain(input string nm, input int budget);
        int n;
        for (n = 0; n < budget; n++) begin
            @(negedge clk);
            if (a_pend.size() == 0 && a_fifo.size() == 0 && a_exp.size() == 0 &&
                a_infl == 3'd0 && !a_valid) break;
        end
        chk(nm, n < budget, 1);
    endtask

    typedef struct {
        logic       rd;
        logic       vld;
        logic [7:0] dat;
        logic [3:0] wc;
    } vec_t;
    vec_t tv [13];

    initial begin
        int snap, cnt, n;
        // Back-to-back drain of ten words at READ_LATENCY=1, cycle 0 = first fifo_read.
        for (int i = 0; i < 13; i++) begin
            tv[i].rd  = (i <= 9);
            tv[i].vld = (i >= 2 && i <= 11);
            tv[i].dat = 8'(i - 1);
            tv[i].wc  = (i >= 3) ? 4'(i - 2) : 4'd0;
        end

        rst_n = 1'b0; a_ready = 1'b1; b_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_a_rd", a_rd, 0);       chk("rst_a_vld", a_valid, 0);
        chk("rst_a_dat", a_mdata, 0);   chk("rst_a_buf", a_buf, 0);
        chk("rst_a_infl", a_infl, 0);   chk("rst_a_wc", a_wc, 0);
        chk("rst_b_vld", b_valid, 0);   chk("rst_b_wc", b_wc, 0);
        rst_n = 1'b1;

        // Empty FIFO: nothing may be issued or presented.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_rd", a_rd, 0);
            chk("idle_vld", a_valid, 0);
            chk("idle_wc", a_wc, 0);
        end

        for (int k = 1; k <= 10; k++) a_pend.push_back(8'(k));
        @(posedge clk);
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            chk($sformatf("vec%0d_rd", i), a_rd, tv[i].rd);
            chk($sformatf("vec%0d_vld", i), a_valid, tv[i].vld);
            if (tv[i].vld) chk($sformatf("vec%0d_dat", i), a_mdata, tv[i].dat);
            chk($sformatf("vec%0d_wc", i), a_wc, tv[i].wc);
        end

        // Backpressure: exactly BUF_DEPTH reads, then hold the first word.
        a_ready = 1'b0;
        for (int k = 0; k < 16; k++) a_pend.push_back(8'h10 + 8'(k));
        snap = a_got;
        cnt = 0;
        @(posedge clk);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (a_rd) cnt++;
        end
        chk("bp_read_pulses", cnt, 3);
        chk("bp_buf_full", a_buf, 3);
        chk("bp_inflight", a_infl, 0);
        chk("bp_head_word", a_mdata, 8'h10);
        a_ready = 1'b1;
        wait_a_drain("bp_drain_timeout", 200);
        chk("bp_drained", a_got - snap, 16);
        chk("bp_wc", a_wc, 4'd10);

        // Asynchronous reset with two words buffered and one in flight.
        a_ready = 1'b0;
        for (int k = 0; k < 16; k++) a_pend.push_back(8'h40 + 8'(k));
        @(posedge clk);
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (a_buf == 3'd2 && a_infl == 3'd1) break;
        end
        chk("rst_setup_reached", n < 20, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_rd", a_rd, 0);     chk("mid_rst_vld", a_valid, 0);
        chk("mid_rst_dat", a_mdata, 0); chk("mid_rst_buf", a_buf, 0);
        chk("mid_rst_infl", a_infl, 0); chk("mid_rst_wc", a_wc, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Post-reset: first word out is the first written after reset; 17 words wrap the counter.
        a_ready = 1'b1;
        snap = a_got;
        for (int k = 0; k < 17; k++) a_pend.push_back(8'h80 + 8'(k));
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (a_valid) break;
        end
        chk("post_rst_valid_timeout", n < 20, 1);
        chk("post_rst_first_word", a_mdata, 8'h80);
        wait_a_drain("wrap_drain_timeout", 200);
        chk("wrap_delivered", a_got - snap, 17);
        chk("wrap_wc", a_wc, 4'd1);

        // READ_LATENCY=3 under random backpressure, 1000 words.
        snap = b_got;
        for (int k = 0; k < 1000; k++) b_pend.push_back(8'($urandom));
        for (n = 0; n < 20000; n++) begin
            @(posedge clk);
            #1 b_ready = 1'($urandom_range(0, 1));
            if (b_got - snap >= 1000) break;
        end
        chk("b_random_timeout", n < 20000, 1);
        b_ready = 1'b1;
        @(negedge clk);
        chk("b_delivered", b_got - snap, 1000);
        chk("b_wc", b_wc, 16'd1000);
        chk("b_buf_empty", b_buf, 0);
        chk("b_inflight_empty", b_infl, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
